// File: rtl/window_read_arbiter.sv
// Round-robin arbiter for the match-engine window buffer read port.
// Grants at most one read per cycle, tracks the requester of each read
// through a tag pipeline that advances with buf_read_enable, and returns
// data/unsafe to the originating requester. Issues flush reads to drain
// results when nobody is requesting.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef MATCH_PU_WIDTH
`define MATCH_PU_WIDTH 8
`endif

module window_read_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned REQ_IDX_W = 2,
    // Must be at least 2: the last stage never needs a further shift.
    parameter int unsigned READ_LAT  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*`ADDR_WIDTH-1:0]    req_addr,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic                              grant_hold,
    output logic [NUM_REQ-1:0]                resp_valid,
    output logic [`MATCH_PU_WIDTH*8-1:0]      resp_data,
    output logic                              resp_unsafe,
    output logic                              buf_read_enable,
    output logic [`ADDR_WIDTH-1:0]            buf_read_address,
    input  logic [`MATCH_PU_WIDTH*8-1:0]      buf_read_data,
    input  logic                              buf_read_unsafe,
    output logic                              busy
);

    localparam int unsigned AW = `ADDR_WIDTH;

    // Round-robin pointer: index of the last granted requester.
    logic [REQ_IDX_W-1:0] rr_q, rr_d;

    // Last issued address, replayed on flush reads.
    logic [AW-1:0] addr_q, addr_d;

    // Tag pipeline: one {valid, idx} per outstanding buffer read stage.
    logic [READ_LAT-1:0]  tag_vld_q, tag_vld_d;
    logic [REQ_IDX_W-1:0] tag_idx_q [READ_LAT];
    logic [REQ_IDX_W-1:0] tag_idx_d [READ_LAT];

    // Set on every pipeline shift; keeps a parked last-stage tag from
    // strobing resp_valid more than once.
    logic fresh_q, fresh_d;

    logic                 grant_vld;
    logic [REQ_IDX_W-1:0] grant_idx;
    logic [REQ_IDX_W-1:0] cand;
    logic [AW-1:0]        grant_addr;
    logic                 inflight_any;
    logic                 resp_pending;

    // Round-robin search starting one past the last grant; the index wraps
    // naturally because NUM_REQ is a power of two.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        req_ready = '0;
        if (!grant_hold) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                cand = rr_q + REQ_IDX_W'(k);
                if (!grant_vld && req_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign grant_addr = req_addr[grant_idx*AW +: AW];

    // A tag in the last stage already has its data at the buffer outputs,
    // so only the earlier stages need further read_enable edges.
    assign inflight_any = |tag_vld_q[READ_LAT-2:0];

    assign buf_read_enable  = grant_vld | inflight_any;
    assign buf_read_address = grant_vld ? grant_addr : addr_q;

    // Next-state for pointer, address register, tag pipeline and fresh bit.
    always_comb begin
        rr_d      = rr_q;
        addr_d    = addr_q;
        tag_vld_d = tag_vld_q;
        tag_idx_d = tag_idx_q;
        fresh_d   = buf_read_enable;
        if (grant_vld) begin
            rr_d   = grant_idx;
            addr_d = grant_addr;
        end
        if (buf_read_enable) begin
            tag_vld_d[0] = grant_vld;
            tag_idx_d[0] = grant_idx;
            for (int unsigned s = 1; s < READ_LAT; s++) begin
                tag_vld_d[s] = tag_vld_q[s-1];
                tag_idx_d[s] = tag_idx_q[s-1];
            end
        end
    end

    // State registers with synchronous reset; reset drops in-flight reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q      <= REQ_IDX_W'(NUM_REQ - 1);
            addr_q    <= '0;
            tag_vld_q <= '0;
            fresh_q   <= 1'b0;
            for (int unsigned s = 0; s < READ_LAT; s++) begin
                tag_idx_q[s] <= '0;
            end
        end else begin
            rr_q      <= rr_d;
            addr_q    <= addr_d;
            tag_vld_q <= tag_vld_d;
            fresh_q   <= fresh_d;
            tag_idx_q <= tag_idx_d;
        end
    end

    assign resp_pending = fresh_q & tag_vld_q[READ_LAT-1];

    // Response steering: strobe the owner of the last-stage tag once.
    always_comb begin
        resp_valid = '0;
        if (resp_pending) begin
            resp_valid[tag_idx_q[READ_LAT-1]] = 1'b1;
        end
    end

    assign resp_data   = buf_read_data;
    assign resp_unsafe = buf_read_unsafe;

    // Include the response cycle so busy covers every undelivered read.
    assign busy = inflight_any | resp_pending | (|req_valid);

endmodule

// File: tb/tb_window_read_arbiter.sv
// Scoreboard bench for window_read_arbiter with a simple window-buffer model.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef MATCH_PU_WIDTH
`define MATCH_PU_WIDTH 8
`endif

module tb_window_read_arbiter;

    localparam int NR  = 4;
    localparam int IW  = 2;
    localparam int LAT = 4;
    localparam int AW  = `ADDR_WIDTH;
    localparam int DW  = `MATCH_PU_WIDTH * 8;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     req_ready;
    logic              grant_hold;
    logic [NR-1:0]     resp_valid;
    logic [DW-1:0]     resp_data;
    logic              resp_unsafe;
    logic              buf_read_enable;
    logic [AW-1:0]     buf_read_address;
    logic [DW-1:0]     buf_read_data;
    logic              buf_read_unsafe;
    logic              busy;

    logic [AW-1:0]     taddr [NR];

    window_read_arbiter #(
        .NUM_REQ  (NR),
        .REQ_IDX_W(IW),
        .READ_LAT (LAT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_ready       (req_ready),
        .grant_hold      (grant_hold),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_unsafe     (resp_unsafe),
        .buf_read_enable (buf_read_enable),
        .buf_read_address(buf_read_address),
        .buf_read_data   (buf_read_data),
        .buf_read_unsafe (buf_read_unsafe),
        .busy            (busy)
    );

    for (genvar i = 0; i < NR; i++) begin : g_addr
        assign req_addr[i*AW +: AW] = taddr[i];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Window buffer model: data for an address appears LAT read_enable edges later.
    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return DW'({~a, a ^ 32'h5A5A_1234});
    endfunction

    function automatic logic mem_unsafe(input logic [AW-1:0] a);
        return a == 32'h0000_9000;
    endfunction

    logic [AW-1:0] bpipe [LAT];
    always @(posedge clk) begin
        if (buf_read_enable) begin
            for (int s = LAT - 1; s > 0; s--) bpipe[s] <= bpipe[s-1];
            bpipe[0] <= buf_read_address;
        end
    end
    assign buf_read_data   = mem_data(bpipe[LAT-1]);
    assign buf_read_unsafe = mem_unsafe(bpipe[LAT-1]);

    typedef struct {
        logic [NR-1:0] onehot;
        logic [DW-1:0] data;
        logic          unsafe;
        int            due;
    } exp_t;

    exp_t sbq[$];

    int checks      = 0;
    int errors      = 0;
    int en_count    = 0;
    int resp_count  = 0;
    int unsafe_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare every response the DUT presents.
    always @(negedge clk) begin
        if (!rst && resp_valid !== '0) begin
            resp_count++;
            if (resp_unsafe === 1'b1) unsafe_seen++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_valid %0h want none (cycle %0d)",
                         resp_valid, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("resp_valid", 64'(resp_valid), 64'(e.onehot));
                check("resp_data", 64'(resp_data), 64'(e.data));
                check("resp_unsafe", 64'(resp_unsafe), 64'(e.unsafe));
                check("resp_latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    // One cycle of stimulus; exp_en / exp_busy < 0 means "don't check".
    task automatic step(input logic [NR-1:0] v, input logic hold, input logic [NR-1:0] exp_rdy,
                        input int exp_en, input int exp_busy);
        req_valid  = v;
        grant_hold = hold;
        @(negedge clk);
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (exp_en >= 0) check("rd_en", 64'(buf_read_enable), 64'(exp_en));
        if (exp_busy >= 0) check("busy", 64'(busy), 64'(exp_busy));
        if (buf_read_enable === 1'b1) en_count++;
        if (exp_rdy != '0) begin
            exp_t e;
            int   idx;
            idx = 0;
            for (int i = 0; i < NR; i++) if (exp_rdy[i]) idx = i;
            check("rd_addr", 64'(buf_read_address), 64'(taddr[idx]));
            e.onehot = exp_rdy;
            e.data   = mem_data(taddr[idx]);
            e.unsafe = mem_unsafe(taddr[idx]);
            e.due    = cyc + LAT;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b0, '0, -1, -1);
    endtask

    task automatic do_reset(input int n);
        rst        = 1'b1;
        req_valid  = '0;
        grant_hold = 1'b0;
        sbq.delete();
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int rc;
        logic [NR-1:0] sparse_v [4];
        sparse_v[0] = 4'b0001;
        sparse_v[1] = 4'b0100;
        sparse_v[2] = 4'b1000;
        sparse_v[3] = 4'b0010;
        for (int i = 0; i < NR; i++) taddr[i] = '0;
        do_reset(2);

        // Reset state.
        @(negedge clk);
        check("reset_resp_valid", 64'(resp_valid), 64'd0);
        check("reset_rd_en", 64'(buf_read_enable), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Single read: 1 grant + 3 flush reads.
        taddr[0] = 32'h120;
        en_count = 0;
        step(4'b0001, 1'b0, 4'b0001, 1, 1);
        for (int i = 0; i < 3; i++) step('0, 1'b0, '0, 1, 1);
        step('0, 1'b0, '0, 0, 1);
        for (int i = 0; i < 3; i++) step('0, 1'b0, '0, 0, 0);
        check("single_en_count", 64'(en_count), 64'd4);

        // Round-robin fairness.
        do_reset(1);
        taddr[0] = 32'h1000; taddr[1] = 32'h2000; taddr[2] = 32'h3000; taddr[3] = 32'h4000;
        for (int i = 0; i < 8; i++) step(4'hF, 1'b0, NR'(1 << (i % 4)), 1, 1);
        idle(6);

        // Hold drain.
        do_reset(1);
        step(4'hF, 1'b0, 4'b0001, 1, 1);
        step(4'hF, 1'b0, 4'b0010, 1, 1);
        for (int i = 0; i < 3; i++) step(4'hF, 1'b1, '0, 1, 1);
        for (int i = 0; i < 2; i++) step(4'hF, 1'b1, '0, 0, 1);
        idle(2);

        // Unsafe propagation.
        do_reset(1);
        unsafe_seen = 0;
        taddr[1] = 32'h9008; taddr[2] = 32'h9000;
        step(4'b0110, 1'b0, 4'b0010, 1, 1);
        step(4'b0100, 1'b0, 4'b0100, 1, 1);
        idle(6);
        check("unsafe_count", 64'(unsafe_seen), 64'd1);

        // Reset mid-flight.
        do_reset(1);
        taddr[0] = 32'hA0; taddr[1] = 32'hB0; taddr[2] = 32'hC0; taddr[3] = 32'hD0;
        step(4'b0111, 1'b0, 4'b0001, 1, 1);
        step(4'b0111, 1'b0, 4'b0010, 1, 1);
        step(4'b0111, 1'b0, 4'b0100, 1, 1);
        do_reset(1);
        rc = resp_count;
        for (int i = 0; i < 6; i++) step('0, 1'b0, '0, 0, 0);
        check("flushed_resp_count", 64'(resp_count), 64'(rc));
        step(4'hF, 1'b0, 4'b0001, 1, 1);
        step(4'b1000, 1'b0, 4'b1000, 1, 1);
        idle(6);

        // Sparse requests, then a sole requester granted back-to-back.
        do_reset(1);
        rc = resp_count;
        for (int r = 0; r < 4; r++) begin
            step(sparse_v[r], 1'b0, sparse_v[r], 1, 1);
            idle(5);
        end
        check("sparse_resp_count", 64'(resp_count - rc), 64'd4);
        step(4'b0010, 1'b0, 4'b0010, 1, 1);
        step(4'b0010, 1'b0, 4'b0010, 1, 1);
        idle(6);

        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
